display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of time-multiplexed digits (legal range 2..8).
REQ-002 SHALL have parameter PRESCALE, default 50000: clock cycles per digit slot (legal range 2 and up).
REQ-003 SHALL use one clock; reset is asynchronous and active-low. Ports: clock in 1, rising-edge system clock; reset_n in 1, asynchronous active-low reset.
REQ-004 SHALL have port: enable in 1, scanning enabled when high.
REQ-005 SHALL have port: load_valid in 1, new display value offered.
REQ-006 SHALL have port: load_data in 4*NUM_DIGITS, one hex nibble per digit, digit 0 in the LSBs.
REQ-007 SHALL have port: load_ready out 1, pending buffer empty and able to accept.
REQ-008 SHALL have port: digit_code out 4, nibble driven to the shared hex decoder.
REQ-009 SHALL have port: digit_sel out NUM_DIGITS, active-low one-hot digit enable.
REQ-010 SHALL have port: frame_done out 1, one-cycle pulse at the end of each full scan.

Function
REQ-011 SHALL hold internal registers: shown (displayed value), pending (buffered value), pend_full flag, digit index idx, prescale counter cnt, and a state in {BLANK, SCAN}.
REQ-012 SHALL assert load_ready = !pend_full.
REQ-013 SHALL capture load_data into pending and set pend_full on any cycle where load_valid and load_ready are both high.
REQ-014 SHALL raise a tick when state is SCAN and cnt == PRESCALE-1; cnt then wraps to 0, otherwise it increments.
REQ-015 SHALL advance idx on a tick; idx wraps from NUM_DIGITS-1 to 0, and that wrap tick is the frame boundary.
REQ-016 SHALL, at a frame boundary, pulse frame_done for 1 cycle; if pend_full is set, shown <= pending and pend_full clears on that same edge.
REQ-017 SHALL leave load_ready low on a cycle with pend_full set, even if a commit happens that cycle (no capture); load_ready rises on the following cycle.
REQ-018 SHALL let a capture that lands on a frame-boundary cycle while pend_full is clear wait for the next frame boundary before it is shown.
REQ-019 SHALL drive digit_code = shown[4*idx +: 4] combinationally.
REQ-020 SHALL, in SCAN, drive digit_sel with bit idx low and all other bits high.
REQ-021 SHALL, in BLANK, drive digit_sel all ones, frame_done 0, and hold cnt and idx at 0.
REQ-022 SHALL transition BLANK -> SCAN when enable is high and (pend_full is set or shown has been loaded since reset); on entry, pending is committed to shown that same cycle if pend_full.
REQ-023 SHALL transition SCAN -> BLANK on any cycle with enable low; cnt and idx clear, while shown and pending are retained.
REQ-024 SHALL keep the load handshake operational in both states.
REQ-025 SHALL display digit 0 for PRESCALE cycles first after entering SCAN.

Reset
REQ-026 SHALL, while reset_n is low, force asynchronously: state = BLANK, cnt = 0, idx = 0, shown = 0, pending = 0, pend_full = 0, loaded flag = 0.
REQ-027 SHALL hold reset-state outputs: load_ready = 1, digit_sel all ones, digit_code = 0, frame_done = 0.
REQ-028 SHALL abandon a scan in progress when reset is asserted mid-scan, and lose any pending value.

Configuration
REQ-029 SHALL, with LEADING_ZERO_BLANK_EN defined, keep digit_sel high during the slot of every digit above the most significant nonzero nibble of shown. Digit 0 is never blanked (shown == 0 displays a single "0"), and slot timing and idx sequencing are unchanged.
REQ-030 SHALL, with LEADING_ZERO_BLANK_EN undefined, enable every digit in its slot and synthesize no blanking logic.

Structure
REQ-031 SHALL define in package display_pkg: default constants NUM_DIGITS_DEF and PRESCALE_DEF, and the state typedef scan_state_t {BLANK, SCAN}.
REQ-032 SHALL place the prescale counter and tick generation in sub-module scan_prescaler (inputs clock, reset_n, run; output tick).
REQ-033 SHALL keep the hex decoder outside this block; digit_code feeds it.

Verification (NUM_DIGITS=4, PRESCALE=4)
REQ-034 SHALL cover reset release with enable=1 and no load -> stays BLANK, digit_sel=4'b1111, load_ready=1.
REQ-035 SHALL cover loading 16'h1234 then enable=1 -> digit_code sequence 4,3,2,1 with 4 cycles each, digit_sel 1110,1101,1011,0111, and frame_done pulse on the 16th cycle.
REQ-036 SHALL cover loading 16'hABCD mid-frame -> load_ready low until the frame boundary, shown changes exactly at the boundary, and no digit of the old frame shows new data.
REQ-037 SHALL cover a load offered on the frame-boundary cycle while pending is full -> not accepted; accepted on the next cycle once load_ready=1.
REQ-038 SHALL cover enable dropped mid-slot for idx=2 -> digit_sel=1111 next cycle; re-enable restarts at digit 0 with a full 4-cycle slot.
REQ-039 SHALL cover, with LEADING_ZERO_BLANK_EN defined, load 16'h0050 -> slots 2 and 3 stay 1111 and slots 0 and 1 are enabled; load 16'h0000 -> only slot 0 is enabled.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared defaults and scan state type for the display scan controller.
package display_pkg;
    localparam int NUM_DIGITS_DEF = 4;
    localparam int PRESCALE_DEF   = 50000;
    typedef enum logic {BLANK = 1'b0, SCAN = 1'b1} scan_state_t;
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: slot-length counter; tick marks the last cycle of each digit slot.
module scan_prescaler
    import display_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    output logic tick
);
    localparam int CNT_W = $clog2(PRESCALE);
    logic [CNT_W-1:0] r_cnt;
    assign tick = run && (r_cnt == CNT_W'(PRESCALE - 1));
    // Count while running, wrap after the last slot cycle, park at 0 when stopped
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (!run || tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed hex digit scanner with a frame-synchronous double buffer.
// Define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero nibble.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int PRESCALE   = PRESCALE_DEF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    output logic [3:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW    = 4 * NUM_DIGITS;

    scan_state_t      r_state, w_state_nxt;
    logic [DW-1:0]    r_shown, r_pending;
    logic             r_pend_full, r_loaded;
    logic [IDX_W-1:0] r_idx;
    logic             w_run, w_tick, w_wrap, w_boundary, w_enter, w_commit, w_capture, w_lit;

    assign w_run = (r_state == SCAN) && enable;

    scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (w_run),
        .tick    (w_tick)
    );

    assign w_wrap     = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_boundary = w_tick && w_wrap;
    assign w_enter    = (r_state == BLANK) && (w_state_nxt == SCAN);
    assign w_commit   = r_pend_full && (w_boundary || w_enter);
    assign w_capture  = load_valid && !r_pend_full;
    assign load_ready = !r_pend_full;
    assign digit_code = r_shown[4*r_idx +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] w_top;
    // Index of the most significant nonzero nibble; digit 0 when the whole value is zero
    always_comb begin
        w_top = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (r_shown[4*i +: 4] != 4'h0) w_top = IDX_W'(i);
    end
    assign w_lit = (r_idx <= w_top);
`else
    assign w_lit = 1'b1;
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= BLANK;
        else
            r_state <= w_state_nxt;
    end

    // Next state and outputs: scan while enabled once there is something to show
    always_comb begin
        w_state_nxt = (enable && (r_state == SCAN || r_pend_full || r_loaded)) ? SCAN : BLANK;
        frame_done  = w_boundary;
        digit_sel   = '1;
        if (r_state == SCAN && w_lit)
            digit_sel = ~(NUM_DIGITS'(1) << r_idx);
    end

    // Digit index: advances on each slot tick, parked at 0 whenever not scanning
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_idx <= '0;
        else if (!w_run)
            r_idx <= '0;
        else if (w_tick)
            r_idx <= w_wrap ? '0 : r_idx + 1'b1;
    end

    // Display buffers: capture into pending when free, commit at a frame boundary or scan start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shown     <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
            r_loaded    <= 1'b0;
        end else begin
            if (w_capture)
                r_pending <= load_data;
            if (w_commit)
                r_shown <= r_pending;
            r_pend_full <= w_capture || (r_pend_full && !w_commit);
            r_loaded    <= r_loaded || w_commit;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed vector bench for display_scan_ctrl (NUM_DIGITS=4, PRESCALE=4).
module tb_display_scan_ctrl;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_ready;
    logic [3:0]  digit_code;
    logic [3:0]  digit_sel;
    logic        frame_done;
    int          n_vec = 0;
    int          n_err = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    typedef struct {
        logic        en;
        logic        lv;
        logic [15:0] d;
        int          rep;
        logic        rdy;
        logic [3:0]  sel;
        logic [3:0]  code;
        logic        done;
    } vec_t;
    vec_t tbl[$];

    display_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .digit_code (digit_code),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic add(input logic en, input logic lv, input logic [15:0] d, input int rep,
                       input logic rdy, input logic [3:0] sel, input logic [3:0] code, input logic done);
        vec_t v;
        v.en = en; v.lv = lv; v.d = d; v.rep = rep;
        v.rdy = rdy; v.sel = sel; v.code = code; v.done = done;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic rdy, input logic [3:0] sel,
                       input logic [3:0] code, input logic done);
        n_vec++;
        if ({load_ready, digit_sel, digit_code, frame_done} !== {rdy, sel, code, done}) begin
            n_err++;
            $display("FAIL %s: got ready=%b sel=%b code=%h done=%b, want ready=%b sel=%b code=%h done=%b",
                     nm, load_ready, digit_sel, digit_code, frame_done, rdy, sel, code, done);
        end
    endtask

    // Check the outputs for the current cycle, then drive this cycle's inputs and move to the next cycle
    task automatic apply(input string nm, input logic en, input logic lv, input logic [15:0] d,
                         input logic rdy, input logic [3:0] sel, input logic [3:0] code, input logic done);
        chk(nm, rdy, sel, code, done);
        enable = en;
        load_valid = lv;
        load_data = d;
        @(negedge clock);
    endtask

    // One full frame with enable held high and no loads, for value v
    task automatic frame(input string nm, input logic [15:0] v);
        logic [15:0] val;
        logic [3:0]  es;
        val = v;
        for (int k = 0; k < 4; k++) begin
            es = 4'(~(4'b0001 << k));
            if (LZ && k > 0 && (val >> (4 * k)) == 16'h0) es = 4'hF;
            for (int c = 0; c < 4; c++)
                apply($sformatf("%s_s%0d_c%0d", nm, k, c), 1'b1, 1'b0, 16'h0,
                      1'b1, es, val[4*k +: 4], (k == 3 && c == 3));
        end
    endtask

    initial begin
        // Basic scan of 1234 from an idle start
        add(1, 0, 16'h0000, 2, 1, 4'hF, 4'h0, 0);
        add(0, 1, 16'h1234, 1, 1, 4'hF, 4'h0, 0);
        add(0, 0, 16'h0000, 1, 0, 4'hF, 4'h0, 0);
        add(1, 0, 16'h0000, 1, 0, 4'hF, 4'h0, 0);
        add(1, 0, 16'h0000, 4, 1, 4'hE, 4'h4, 0);
        add(1, 0, 16'h0000, 4, 1, 4'hD, 4'h3, 0);
        add(1, 0, 16'h0000, 4, 1, 4'hB, 4'h2, 0);
        add(1, 0, 16'h0000, 3, 1, 4'h7, 4'h1, 0);
        add(1, 0, 16'h0000, 1, 1, 4'h7, 4'h1, 1);
        // ABCD loaded mid-frame waits for the boundary; a load on the boundary is refused
        add(1, 0, 16'h0000, 1, 1, 4'hE, 4'h4, 0);
        add(1, 1, 16'hABCD, 1, 1, 4'hE, 4'h4, 0);
        add(1, 0, 16'h0000, 2, 0, 4'hE, 4'h4, 0);
        add(1, 0, 16'h0000, 4, 0, 4'hD, 4'h3, 0);
        add(1, 0, 16'h0000, 4, 0, 4'hB, 4'h2, 0);
        add(1, 0, 16'h0000, 3, 0, 4'h7, 4'h1, 0);
        add(1, 1, 16'h5678, 1, 0, 4'h7, 4'h1, 1);
        add(1, 1, 16'h5678, 1, 1, 4'hE, 4'hD, 0);
        add(1, 0, 16'h0000, 3, 0, 4'hE, 4'hD, 0);
        add(1, 0, 16'h0000, 4, 0, 4'hD, 4'hC, 0);
        add(1, 0, 16'h0000, 1, 0, 4'hB, 4'hB, 0);
        // Enable dropped in slot 2, then restart commits the pending 5678
        add(0, 0, 16'h0000, 1, 0, 4'hB, 4'hB, 0);
        add(0, 0, 16'h0000, 2, 0, 4'hF, 4'hD, 0);
        add(1, 0, 16'h0000, 1, 0, 4'hF, 4'hD, 0);
        add(1, 0, 16'h0000, 4, 1, 4'hE, 4'h8, 0);
        add(1, 0, 16'h0000, 4, 1, 4'hD, 4'h7, 0);
        add(1, 0, 16'h0000, 4, 1, 4'hB, 4'h6, 0);
        add(1, 0, 16'h0000, 3, 1, 4'h7, 4'h5, 0);
        // Capture on a boundary with pending empty is shown only one frame later
        add(1, 1, 16'h9999, 1, 1, 4'h7, 4'h5, 1);
        add(1, 0, 16'h0000, 4, 0, 4'hE, 4'h8, 0);
        add(1, 0, 16'h0000, 4, 0, 4'hD, 4'h7, 0);
        add(1, 0, 16'h0000, 4, 0, 4'hB, 4'h6, 0);
        add(1, 0, 16'h0000, 3, 0, 4'h7, 4'h5, 0);
        add(1, 0, 16'h0000, 1, 0, 4'h7, 4'h5, 1);
        add(1, 0, 16'h0000, 1, 1, 4'hE, 4'h9, 0);

        @(negedge clock);
        chk("reset_state", 1, 4'hF, 4'h0, 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            for (int k = 0; k < tbl[i].rep; k++)
                apply($sformatf("v%0d_%0d", i, k), tbl[i].en, tbl[i].lv, tbl[i].d,
                      tbl[i].rdy, tbl[i].sel, tbl[i].code, tbl[i].done);

        // Mid-scan reset with a value pending: everything is lost
        apply("pend_before_rst", 1, 1, 16'h1111, 1, 4'hF - 4'h1, 4'h9, 0);
        reset_n = 1'b0;
        #1;
        chk("async_rst", 1, 4'hF, 4'h0, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++)
            apply($sformatf("post_rst_blank%0d", k), 1, 0, 16'h0, 1, 4'hF, 4'h0, 0);

        // 0050 then 0000: leading-zero slots blank only when that option is built in
        apply("load_0050", 0, 1, 16'h0050, 1, 4'hF, 4'h0, 0);
        apply("enter_0050", 1, 0, 16'h0000, 0, 4'hF, 4'h0, 0);
        frame("f0050", 16'h0050);
        apply("stop_load_0000", 0, 1, 16'h0000, 1, 4'hE, 4'h0, 0);
        apply("enter_0000", 1, 0, 16'h0000, 0, 4'hF, 4'h0, 0);
        frame("f0000", 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
